// File: rtl/stage_mem_pkg.sv
// Shared pipeline definitions: ALU opcodes plus the MEM-stage state encoding
// and the word-alignment mask used to reject misaligned data accesses.
package stage_mem_pkg;

  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_AND = 4'd2,
    ALU_OR  = 4'd3,
    ALU_XOR = 4'd4,
    ALU_SLT = 4'd5,
    ALU_SLL = 4'd6,
    ALU_SRL = 4'd7
  } alu_op_e;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } mem_state_e;

  localparam logic [31:0] ALIGN_MASK = 32'h0000_0003;
  localparam int          WAIT_W     = 8;

endpackage

// File: rtl/stage_mem.sv
// MEM pipeline stage: passes ALU results through in one cycle, or runs one
// word access against data memory with a bounded wait before handing to WB.
module stage_mem
  import stage_mem_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] in_inst,
  input  logic [31:0] in_newpc,
  input  logic [31:0] in_aluout,
  input  logic [31:0] in_regb,
  input  logic        in_cond,
  input  logic        cs_memread,
  input  logic        cs_memwrite,
  input  logic        cs_branch,
  output logic        stall,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        out_valid,
  output logic [31:0] out_inst,
  output logic [31:0] out_aluout,
  output logic [31:0] out_lmd,
  output logic        br_taken,
  output logic [31:0] br_target,
  output logic        mem_err
);

  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT);

  mem_state_e        state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;
  logic [31:0]       inst_q, addr_q, wdata_q;
  logic              we_q, br_q;

  logic mem_op, misaligned;
  logic pass_thru, reject, start, done_ok, done_to;

  // The PC+4 value is not needed past EX in this stage.
  logic unused_newpc;
  assign unused_newpc = ^in_newpc;

  assign mem_op     = cs_memread | cs_memwrite;
  assign misaligned = |(in_aluout & ALIGN_MASK);

  assign stall     = (state_q == ST_ACCESS);
  assign mem_req   = stall;
  assign mem_we    = stall & we_q;
  assign mem_addr  = stall ? addr_q  : 32'd0;
  assign mem_wdata = stall ? wdata_q : 32'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  // Ack wins over the wait limit when both land in the same cycle.
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    pass_thru = 1'b0;
    reject    = 1'b0;
    start     = 1'b0;
    done_ok   = 1'b0;
    done_to   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          if (!mem_op) begin
            pass_thru = 1'b1;
          end else if (misaligned) begin
            reject = 1'b1;
          end else begin
            start   = 1'b1;
            state_d = ST_ACCESS;
            wait_d  = '0;
          end
        end
      end
      ST_ACCESS: begin
        if (mem_ack) begin
          done_ok = 1'b1;
          state_d = ST_IDLE;
        end else if (wait_q + 1'b1 == WAIT_LIMIT) begin
          done_to = 1'b1;
          state_d = ST_IDLE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_q     <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      br_q       <= 1'b0;
      out_valid  <= 1'b0;
      out_inst   <= '0;
      out_aluout <= '0;
      out_lmd    <= '0;
      br_taken   <= 1'b0;
      br_target  <= '0;
      mem_err    <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      br_taken  <= 1'b0;
      mem_err   <= 1'b0;
      if (pass_thru || reject) begin
        out_valid  <= 1'b1;
        out_inst   <= in_inst;
        out_aluout <= in_aluout;
        out_lmd    <= '0;
        mem_err    <= reject;
        br_taken   <= cs_branch & in_cond;
        if (cs_branch && in_cond) br_target <= in_aluout;
      end
      if (start) begin
        inst_q  <= in_inst;
        addr_q  <= in_aluout;
        wdata_q <= in_regb;
        we_q    <= cs_memwrite;
        br_q    <= cs_branch & in_cond;
      end
      // Stores and timed-out accesses report a zero load value.
      if (done_ok || done_to) begin
        out_valid  <= 1'b1;
        out_inst   <= inst_q;
        out_aluout <= addr_q;
        out_lmd    <= (done_ok && !we_q) ? mem_rdata : 32'd0;
        mem_err    <= done_to;
        br_taken   <= br_q;
        if (br_q) br_target <= addr_q;
      end
    end
  end

endmodule

// File: tb/tb_stage_mem.sv
// Directed bench for stage_mem: expectations are computed when each
// instruction is driven, queued, and checked when WB output appears.
module tb_stage_mem;

  localparam int TIMEOUT_TB = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_inst, in_newpc, in_aluout, in_regb;
  logic        in_cond, cs_memread, cs_memwrite, cs_branch;
  logic        stall, mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;
  logic        out_valid;
  logic [31:0] out_inst, out_aluout, out_lmd;
  logic        br_taken;
  logic [31:0] br_target;
  logic        mem_err;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] alu;
    logic [31:0] lmd;
    logic        err;
    logic        br;
    logic [31:0] wdata;
    logic        we;
    int          stalls;
  } exp_t;

  exp_t sb[$];
  int   tests_run = 0;
  int   tests_failed = 0;
  int   ack_after_q;
  logic [31:0] rdata_q;

  stage_mem #(.TIMEOUT(TIMEOUT_TB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_inst    (in_inst),
    .in_newpc   (in_newpc),
    .in_aluout  (in_aluout),
    .in_regb    (in_regb),
    .in_cond    (in_cond),
    .cs_memread (cs_memread),
    .cs_memwrite(cs_memwrite),
    .cs_branch  (cs_branch),
    .stall      (stall),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack),
    .out_valid  (out_valid),
    .out_inst   (out_inst),
    .out_aluout (out_aluout),
    .out_lmd    (out_lmd),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .mem_err    (mem_err)
  );

  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; drives one instruction for a single cycle.
  task automatic applyStimulus(input logic [31:0] inst, input logic [31:0] alu,
                               input logic [31:0] regb, input logic rd, input logic wr,
                               input logic br, input logic cond, input int ack_after,
                               input logic [31:0] rdata, input bit push);
    exp_t e;
    e.inst  = inst;
    e.alu   = alu;
    e.br    = br & cond;
    e.wdata = regb;
    e.we    = wr;
    if (!(rd || wr)) begin
      e.lmd = 32'd0; e.err = 1'b0; e.stalls = 0;
    end else if (alu[1:0] != 2'b00) begin
      e.lmd = 32'd0; e.err = 1'b1; e.stalls = 0;
    end else if (ack_after >= 1 && ack_after <= TIMEOUT_TB) begin
      e.lmd = rd ? rdata : 32'd0; e.err = 1'b0; e.stalls = ack_after;
    end else begin
      e.lmd = 32'd0; e.err = 1'b1; e.stalls = TIMEOUT_TB;
    end
    if (push) sb.push_back(e);
    ack_after_q = ack_after;
    rdata_q     = rdata;
    in_valid    = 1'b1;
    in_inst     = inst;
    in_newpc    = inst + 32'd4;
    in_aluout   = alu;
    in_regb     = regb;
    cs_memread  = rd;
    cs_memwrite = wr;
    cs_branch   = br;
    in_cond     = cond;
    @(posedge clk);
    #1;
    in_valid    = 1'b0;
    cs_memread  = 1'b0;
    cs_memwrite = 1'b0;
    cs_branch   = 1'b0;
    in_cond     = 1'b0;
  endtask

  // Services the memory handshake and compares the WB result against the queue head.
  task automatic checkOutput(input string tag);
    exp_t e;
    int   stalls = 0;
    bit   seen = 0;
    e = sb.pop_front();
    for (int cyc = 0; cyc < 20 && !seen; cyc++) begin
      @(negedge clk);
      if (out_valid) begin
        seen    = 1;
        mem_ack = 1'b0;
      end else if (stall) begin
        stalls++;
        checkVal({tag, ".req"},   {31'd0, mem_req}, 32'd1);
        checkVal({tag, ".addr"},  mem_addr, e.alu);
        checkVal({tag, ".we"},    {31'd0, mem_we}, {31'd0, e.we});
        checkVal({tag, ".wdata"}, mem_wdata, e.we ? e.wdata : mem_wdata);
        if (stalls == ack_after_q) begin
          mem_ack   = 1'b1;
          mem_rdata = rdata_q;
        end else begin
          mem_ack   = 1'b0;
          mem_rdata = 32'hA5A5_A5A5;
        end
      end
    end
    mem_ack = 1'b0;
    checkVal({tag, ".valid"}, {31'd0, seen}, 32'd1);
    if (seen) begin
      checkVal({tag, ".inst"},   out_inst, e.inst);
      checkVal({tag, ".aluout"}, out_aluout, e.alu);
      checkVal({tag, ".lmd"},    out_lmd, e.lmd);
      checkVal({tag, ".err"},    {31'd0, mem_err}, {31'd0, e.err});
      checkVal({tag, ".br"},     {31'd0, br_taken}, {31'd0, e.br});
      if (e.br) checkVal({tag, ".brtgt"}, br_target, e.alu);
      checkVal({tag, ".stalls"}, stalls, e.stalls);
      checkVal({tag, ".stall"},  {31'd0, stall}, 32'd0);
      checkVal({tag, ".noreq"},  {31'd0, mem_req}, 32'd0);
      @(negedge clk);
      checkVal({tag, ".pulse"},
               {29'd0, out_valid, br_taken, mem_err}, 32'd0);
    end
  endtask

  initial begin
    bit leaked;
    rst_n = 1'b0; in_valid = 1'b0; in_inst = '0; in_newpc = '0; in_aluout = '0;
    in_regb = '0; in_cond = 1'b0; cs_memread = 1'b0; cs_memwrite = 1'b0;
    cs_branch = 1'b0; mem_rdata = '0; mem_ack = 1'b0;
    #3;
    checkVal("reset.outs", {27'd0, out_valid, stall, mem_req, br_taken, mem_err}, 32'd0);
    checkVal("reset.lmd", out_lmd, 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    applyStimulus(32'h0000_0013, 32'h0000_0010, 32'h0, 0, 0, 0, 0, 0, 32'h0, 1);
    checkOutput("alu");
    applyStimulus(32'h0000_0103, 32'h0000_0100, 32'h0, 1, 0, 0, 0, 3, 32'hDEAD_BEEF, 1);
    checkOutput("load");
    applyStimulus(32'h0000_0123, 32'h0000_0102, 32'h1111_2222, 0, 1, 0, 0, 1, 32'h0, 1);
    checkOutput("misalign");
    applyStimulus(32'h0000_0203, 32'h0000_0104, 32'h0, 1, 0, 0, 0, 0, 32'h0, 1);
    checkOutput("timeout");
    applyStimulus(32'h0000_0303, 32'h0000_0108, 32'h0, 1, 0, 0, 0, TIMEOUT_TB, 32'h1234_5678, 1);
    checkOutput("ack_at_limit");
    applyStimulus(32'h0000_0423, 32'h0000_0300, 32'hCAFE_F00D, 0, 1, 0, 0, 1, 32'hFFFF_FFFF, 1);
    checkOutput("store");
    applyStimulus(32'h0000_0563, 32'h0000_0040, 32'h0, 0, 0, 1, 1, 0, 32'h0, 1);
    checkOutput("br_taken");
    applyStimulus(32'h0000_0663, 32'h0000_0080, 32'h0, 0, 0, 1, 0, 0, 32'h0, 1);
    checkOutput("br_not");

    mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
    @(negedge clk); @(negedge clk);
    mem_ack = 1'b0;
    checkVal("idle_ack", {30'd0, out_valid, stall}, 32'd0);

    applyStimulus(32'h0000_0703, 32'h0000_0200, 32'h0, 1, 0, 0, 0, 0, 32'h0, 0);
    @(negedge clk); @(negedge clk);
    checkVal("rst_mid.pre", {31'd0, stall}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkVal("rst_mid.outs", {27'd0, out_valid, stall, mem_req, br_taken, mem_err}, 32'd0);
    checkVal("rst_mid.addr", mem_addr, 32'd0);
    @(negedge clk);
    rst_n = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h7777_7777;
    @(negedge clk);
    mem_ack = 1'b0;
    leaked = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (out_valid || stall) leaked = 1;
    end
    checkVal("rst_mid.late_ack", {31'd0, leaked}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
